// File: rtl/pong_pkg.sv
// Shared encodings and defaults for the pong game controller: state codes,
// player codes and a constant-time BCD conversion helper.
package pong_pkg;

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;

  localparam logic PLAYER_A = 1'b0;
  localparam logic PLAYER_B = 1'b1;

  localparam int WIN_SCORE_DEF   = 5;
  localparam int DELAY_TICKS_DEF = 120;

  function automatic logic [7:0] to_bcd(input int value);
    return {4'(value / 10), 4'(value % 10)};
  endfunction

endpackage

// File: rtl/bcd_cnt2.sv
// Two-digit BCD up-counter (00..99, wraps) with synchronous clear
// taking priority over increment.
module bcd_cnt2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] count
);

  logic [3:0] units;
  logic [3:0] tens;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      units <= 4'd0;
      tens  <= 4'd0;
    end else if (clr) begin
      units <= 4'd0;
      tens  <= 4'd0;
    end else if (inc) begin
      if (units == 4'd9) begin
        units <= 4'd0;
        tens  <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

  assign count = {tens, units};

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve, rally scoring, pause timer and game-over.
// PONG_AUTO_SERVE_EN: when defined, NEWBALL serves automatically once the pause expires.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = WIN_SCORE_DEF,
  parameter int DELAY_TICKS = DELAY_TICKS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_start,
  input  logic       hit_A,
  input  logic       hit_B,
  input  logic       miss,
  output logic       gra_still,
  output logic [7:0] score_A,
  output logic [7:0] score_B,
  output logic       game_over,
  output logic       winner,
  output logic [1:0] state
);

  // Comparing the pre-increment score against WIN_SCORE-1 avoids an adder in the win check.
  localparam logic [7:0] WIN_LAST = to_bcd(WIN_SCORE - 1);
  localparam logic [7:0] DELAY_LD = 8'(DELAY_TICKS);

  state_t     state_q, state_d;
  logic       last_hit_q, last_hit_d;
  logic       winner_q, winner_d;
  logic [7:0] timer_q;
  logic       timer_zero;
  logic       score_evt;
  logic       win_hit;
  logic       clr_scores;
  logic       inc_a, inc_b;

  assign timer_zero = (timer_q == 8'd0);
  assign score_evt  = (state_q == PLAY) && miss && !hit_A && !hit_B;
  assign win_hit    = (last_hit_q == PLAYER_A) ? (score_A == WIN_LAST) : (score_B == WIN_LAST);
  assign inc_a      = score_evt && (last_hit_q == PLAYER_A);
  assign inc_b      = score_evt && (last_hit_q == PLAYER_B);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= NEWGAME;
      last_hit_q <= PLAYER_A;
      winner_q   <= PLAYER_A;
    end else begin
      state_q    <= state_d;
      last_hit_q <= last_hit_d;
      winner_q   <= winner_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_hit_d = last_hit_q;
    winner_d   = winner_q;
    clr_scores = 1'b0;
    case (state_q)
      NEWGAME: begin
        if (btn_start) begin
          state_d    = PLAY;
          last_hit_d = PLAYER_A;
        end
      end
      PLAY: begin
        if (score_evt) begin
          if (win_hit) begin
            state_d  = OVER;
            winner_d = last_hit_q;
          end else begin
            state_d = NEWBALL;
          end
        end else if (hit_A && !hit_B) begin
          last_hit_d = PLAYER_A;
        end else if (hit_B && !hit_A) begin
          last_hit_d = PLAYER_B;
        end
      end
      NEWBALL: begin
`ifdef PONG_AUTO_SERVE_EN
        if (timer_zero) state_d = PLAY;
`else
        if (timer_zero && btn_start) state_d = PLAY;
`endif
      end
      OVER: begin
        if (timer_zero && btn_start) begin
          state_d    = NEWGAME;
          winner_d   = PLAYER_A;
          clr_scores = 1'b1;
        end
      end
      default: state_d = NEWGAME;
    endcase
  end

  // Load beats tick so a point scored on a frame pulse still gets the full pause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     timer_q <= 8'd0;
    else if (score_evt)            timer_q <= DELAY_LD;
    else if (tick && !timer_zero)  timer_q <= timer_q - 8'd1;
  end

  bcd_cnt2 u_score_a (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_a),
    .clr   (clr_scores),
    .count (score_A)
  );

  bcd_cnt2 u_score_b (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_b),
    .clr   (clr_scores),
    .count (score_B)
  );

  assign state     = state_q;
  assign gra_still = (state_q != PLAY);
  assign game_over = (state_q == OVER);
  assign winner    = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed scenarios then random play,
// compared against an integer-score game model.
module tb_pong_game_ctrl;

  localparam int WIN = 10;
  localparam int DLY = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       btn_start = 1'b0;
  logic       hit_A = 1'b0;
  logic       hit_B = 1'b0;
  logic       miss = 1'b0;
  logic       gra_still;
  logic [7:0] score_A;
  logic [7:0] score_B;
  logic       game_over;
  logic       winner;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  // Model: state code, integer scores, last hitter (0=A,1=B), winner, pause ticks left.
  int m_state, m_sa, m_sb, m_lh, m_win, m_tmr;

`ifdef PONG_AUTO_SERVE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  pong_game_ctrl #(.WIN_SCORE(WIN), .DELAY_TICKS(DLY)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .btn_start (btn_start),
    .hit_A     (hit_A),
    .hit_B     (hit_B),
    .miss      (miss),
    .gra_still (gra_still),
    .score_A   (score_A),
    .score_B   (score_B),
    .game_over (game_over),
    .winner    (winner),
    .state     (state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic model_reset();
    m_state = 0; m_sa = 0; m_sb = 0; m_lh = 0; m_win = 0; m_tmr = 0;
  endtask

  task automatic model_step(input bit t, input bit bs, input bit ha, input bit hb, input bit m);
    bit scored;
    scored = (m_state == 1) && m && !ha && !hb;
    case (m_state)
      0: if (bs) begin m_state = 1; m_lh = 0; end
      1: begin
        if (scored) begin
          if (m_lh == 0) m_sa++; else m_sb++;
          if (((m_lh == 0) ? m_sa : m_sb) == WIN) begin
            m_state = 3; m_win = m_lh;
          end else begin
            m_state = 2;
          end
        end else if (ha && !hb) m_lh = 0;
        else if (hb && !ha) m_lh = 1;
      end
      2: if (m_tmr == 0 && (AUTO || bs)) m_state = 1;
      3: if (m_tmr == 0 && bs) begin m_state = 0; m_sa = 0; m_sb = 0; m_win = 0; end
      default: m_state = 0;
    endcase
    if (scored) m_tmr = DLY;
    else if (t && m_tmr > 0) m_tmr--;
  endtask

  task automatic check(input string tag);
    total++;
    assert (state === 2'(m_state)) else begin
      bad++; $error("FAIL %s state got=%0d exp=%0d", tag, state, m_state);
    end
    total++;
    assert (gra_still === (m_state != 1)) else begin
      bad++; $error("FAIL %s gra_still got=%0b exp=%0b", tag, gra_still, (m_state != 1));
    end
    total++;
    assert (score_A === bcd(m_sa)) else begin
      bad++; $error("FAIL %s score_A got=%h exp=%h", tag, score_A, bcd(m_sa));
    end
    total++;
    assert (score_B === bcd(m_sb)) else begin
      bad++; $error("FAIL %s score_B got=%h exp=%h", tag, score_B, bcd(m_sb));
    end
    total++;
    assert (game_over === (m_state == 3)) else begin
      bad++; $error("FAIL %s game_over got=%0b exp=%0b", tag, game_over, (m_state == 3));
    end
    total++;
    assert (winner === 1'(m_win)) else begin
      bad++; $error("FAIL %s winner got=%0b exp=%0d", tag, winner, m_win);
    end
  endtask

  task automatic cyc(input bit t, input bit bs, input bit ha, input bit hb, input bit m,
                     input string tag);
    tick = t; btn_start = bs; hit_A = ha; hit_B = hb; miss = m;
    @(posedge clk);
    model_step(t, bs, ha, hb, m);
    #1;
    check(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    model_reset();
    #2;
    check(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Serve from whatever non-PLAY state the model is in, then one hit and a miss.
  task automatic rally(input bit ha, input bit hb, input string tag);
    for (int i = 0; i < 20 && m_state != 1; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, tag);
    total++;
    assert (m_state == 1) else begin
      bad++; $error("FAIL %s serve_timeout got=%0d exp=1", tag, m_state);
    end
    cyc(1'b0, 1'b0, ha, hb, 1'b0, tag);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, tag);
  endtask

  initial begin
    #1 reset = 1'b1;
    model_reset();
    #1 check("reset");
    @(negedge clk);
    reset = 1'b0;

    // No serve without btn_start, whatever the play inputs do.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "idle");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "idle");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "start");

    // B hits, miss held for 50 clocks: exactly one point.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "hit_b");
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "miss_held");

    // Pause countdown with btn_start held, then a clock without it.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "pause1");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "pause2");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "pause3");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "pause_nobtn");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "serve");

    // Hit and miss together: miss ignored; then a plain miss scores for A.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "hit_miss");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "both_miss");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "miss_a");

    // A runs up to 09, then the carry to 10 ends the game.
    for (int i = 0; i < 12 && m_sa < WIN - 1; i++) rally(1'b1, 1'b0, "run_a");
    rally(1'b1, 1'b0, "carry_win");

    // OVER: start ignored while pausing, accepted once the pause expires.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "over_btn_early");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "over_tick");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "over_tick");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "over_tick");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "over_restart");

    // Random play with occasional mid-game resets.
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) do_reset("rand_reset");
      cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 5) == 0), "random");
    end

    // Drive to OVER and reset asynchronously there.
    for (int i = 0; i < 3000 && m_state != 3; i++) begin
      if (m_state == 1) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "to_over");
      else cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "to_over");
    end
    total++;
    assert (m_state == 3) else begin
      bad++; $error("FAIL to_over_timeout got=%0d exp=3", m_state);
    end
    do_reset("reset_in_over");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 5, points that end a game (legal range 1-99).
REQ-002 Parameter DELAY_TICKS, default 120, pause length in tick pulses (2 s at 60 Hz).
REQ-003 clk  input  1  system clock.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 tick  input  1  one-clk frame pulse, once per vertical retrace.
REQ-006 btn_start  input  1  synchronized, debounced start/serve request.
REQ-007 hit_A  input  1  ball contacted right paddle (A); level, sampled every clk.
REQ-008 hit_B  input  1  ball contacted left paddle (B); level, sampled every clk.
REQ-009 miss  input  1  ball outside play field; level, held while outside.
REQ-010 gra_still  output  1  freeze ball at centre, serve direction reloaded.
REQ-011 score_A  output  8  two-digit BCD score of player A ([7:4] tens).
REQ-012 score_B  output  8  two-digit BCD score of player B.
REQ-013 game_over  output  1  game finished, winner valid.
REQ-014 winner  output  1  0 = A won, 1 = B won; meaningful only with game_over.
REQ-015 state  output  2  current state code, for text overlay selection.

Function
REQ-016 States: NEWGAME(00), PLAY(01), NEWBALL(10), OVER(11); all outputs decoded from registers, valid the cycle after the causing edge.
REQ-017 gra_still = 1 in NEWGAME, NEWBALL, OVER; 0 only in PLAY.
REQ-018 NEWGAME: btn_start = 1 -> PLAY next cycle; scores held at 00.
REQ-019 last_hit register: hit_A sets A, hit_B sets B; both high same cycle -> unchanged; updated only in PLAY.
REQ-020 PLAY, miss = 1 and no hit_A/hit_B that cycle: player last_hit scores +1 (BCD, units 9 -> 0 with tens carry), timer loaded with DELAY_TICKS.
REQ-021 hit_A or hit_B concurrent with miss: miss ignored that cycle.
REQ-022 After scoring: new score == WIN_SCORE -> OVER, winner = scorer; else -> NEWBALL.
REQ-023 Only one point per rally: miss is acted on only in PLAY; state leaves PLAY on the same edge as the increment.
REQ-024 Timer decrements by 1 only on tick, saturates at 0; tick and load same cycle -> load wins.
REQ-025 NEWBALL: leaves to PLAY per REQ-033/034; last_hit reset to A on entry to PLAY from NEWGAME only.
REQ-026 OVER: game_over = 1; timer == 0 and btn_start = 1 -> NEWGAME, both scores cleared to 00, winner cleared to 0.
REQ-027 btn_start while timer != 0 ignored in NEWBALL and OVER.
REQ-028 hit/miss inputs ignored outside PLAY; scores never change outside PLAY except the clear in REQ-026.

Reset
REQ-029 reset asserted: state NEWGAME, gra_still 1, score_A/score_B 00, game_over 0, winner 0, last_hit A, timer 0; effective immediately, mid-game included.
REQ-030 First state change after deassertion requires a clk edge with btn_start = 1.

Configuration
REQ-031 Macro PONG_AUTO_SERVE_EN selects the NEWBALL exit condition.
REQ-032 Gating applies only to NEWBALL; OVER behaviour identical in both builds.
REQ-033 Defined: NEWBALL -> PLAY when timer == 0, btn_start ignored.
REQ-034 Undefined: NEWBALL -> PLAY when timer == 0 and btn_start = 1.

Structure
REQ-035 Package pong_pkg holds the state encoding constants, player encoding (A=0, B=1) and default WIN_SCORE/DELAY_TICKS values.
REQ-036 Sub-module bcd_cnt2 (two-digit BCD incrementer, inc/clr inputs, async reset) instantiated once per player.
REQ-037 Timer width 8 bits; DELAY_TICKS > 255 is illegal.

Verification
REQ-038 Reset, btn_start pulse -> state 01 and gra_still 0 one cycle later; scores 00.
REQ-039 PLAY, hit_B then miss held 50 clks -> score_B = 01 exactly once, state 10, gra_still 1.
REQ-040 Score A at 09, A last hit, miss -> score_A = 10 (tens carry); with WIN_SCORE=10 -> state 11, game_over 1, winner 0.
REQ-041 NEWBALL, DELAY_TICKS=3, btn_start held: 2 ticks -> stays 10; 3rd tick -> 01 only if PONG_AUTO_SERVE_EN defined or btn_start held.
REQ-042 hit_A and miss same cycle in PLAY -> no score change, state stays 01, last_hit = A.
REQ-043 reset asserted in OVER -> state 00, scores 00, game_over 0 without a clk edge.
